// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped I/O port controller: FSM states,
// register offsets above the data ports and the wait-state counter width.
package io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } io_state_t;

  localparam int unsigned WAIT_CNT_W = 4;

  function automatic int unsigned OFS_MASK(input int unsigned num_ports);
    return num_ports;
  endfunction

  function automatic int unsigned OFS_STATUS(input int unsigned num_ports);
    return num_ports + 1;
  endfunction

endpackage

// File: rtl/io_sync_edge.sv
// Two-flop input synchroniser for one port, with a third stage kept only to
// flag that the synchronised value differs from the previous sample.
module io_sync_edge #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              changed
);

  logic [DATA_W-1:0] s1, s2, s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q       = s2;
  assign changed = (s2 != s3);

endmodule

// File: rtl/io_port_ctrl.sv
// Memory-mapped controller for NUM_PORTS output/input byte ports plus MASK and
// STATUS registers, accessed through a start/ack handshake with wait states.
module io_port_ctrl
  import io_pkg::*;
#(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       NUM_PORTS = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       WAIT_CYC  = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           inreg1,
  input  logic [DATA_W-1:0]           inreg2,
  input  logic                        writeRgDir,
  input  logic                        io_start,
  input  logic                        io_we,
  input  logic [DATA_W-1:0]           wdata,
  output logic [DATA_W-1:0]           rdata,
  output logic                        io_ack,
  output logic                        io_busy,
  output logic [ADDR_W-1:0]           dir,
  output logic [NUM_PORTS*DATA_W-1:0] port_out,
  output logic [NUM_PORTS-1:0]        port_wstb,
  input  logic [NUM_PORTS*DATA_W-1:0] port_in,
  output logic                        irq
);

  localparam int unsigned NB = (NUM_PORTS < DATA_W) ? NUM_PORTS : DATA_W;

  io_state_t             state;
  logic [WAIT_CNT_W-1:0] wcnt;

  logic                  op_we, op_hit;
  logic [ADDR_W-1:0]     op_ofs;
  logic [DATA_W-1:0]     op_wdata;

  logic                  cur_we, cur_hit;
  logic [ADDR_W-1:0]     cur_ofs;
  logic [DATA_W-1:0]     cur_wdata;

  logic [ADDR_W:0]       dir_diff;
  logic                  enter_ack;
  logic [NUM_PORTS-1:0]  mask, status, chg, clr;
  logic [NUM_PORTS*DATA_W-1:0] sync_q;
  logic [DATA_W-1:0]     rd_val;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_sync
    io_sync_edge #(.DATA_W(DATA_W)) u_sync (
      .clk    (clk),
      .reset  (reset),
      .d      (port_in[k*DATA_W +: DATA_W]),
      .q      (sync_q[k*DATA_W +: DATA_W]),
      .changed(chg[k])
    );
  end

  // Borrow bit marks dir below BASE_ADDR, which is unmapped.
  assign dir_diff = {1'b0, dir} - {1'b0, BASE_ADDR};
  assign io_busy  = (state != ST_IDLE);

  // With no wait states the access completes on the edge that accepts it, so
  // the operation is taken straight from the inputs while still in IDLE.
  always_comb begin
    if (state == ST_IDLE) begin
      cur_we    = io_we;
      cur_hit   = ~dir_diff[ADDR_W];
      cur_ofs   = dir_diff[ADDR_W-1:0];
      cur_wdata = wdata;
    end else begin
      cur_we    = op_we;
      cur_hit   = op_hit;
      cur_ofs   = op_ofs;
      cur_wdata = op_wdata;
    end
  end

  always_comb begin
    enter_ack = 1'b0;
    case (state)
      ST_IDLE: enter_ack = io_start && (WAIT_CYC == 0);
      ST_WAIT: enter_ack = (wcnt == WAIT_CNT_W'(WAIT_CYC - 1));
      default: enter_ack = 1'b0;
    endcase
  end

  always_comb begin
    rd_val = '0;
    if (cur_hit) begin
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        if (cur_ofs == ADDR_W'(k)) rd_val = sync_q[k*DATA_W +: DATA_W];
      end
      if (cur_ofs == ADDR_W'(OFS_MASK(NUM_PORTS)))   rd_val[NB-1:0] = mask[NB-1:0];
      if (cur_ofs == ADDR_W'(OFS_STATUS(NUM_PORTS))) rd_val[NB-1:0] = status[NB-1:0];
    end
  end

  always_comb begin
    clr = '0;
    if (enter_ack && cur_we && cur_hit && (cur_ofs == ADDR_W'(OFS_STATUS(NUM_PORTS))))
      clr[NB-1:0] = cur_wdata[NB-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      wcnt      <= '0;
      op_we     <= 1'b0;
      op_hit    <= 1'b0;
      op_ofs    <= '0;
      op_wdata  <= '0;
      dir       <= '0;
      port_out  <= '0;
      port_wstb <= '0;
      rdata     <= '0;
      io_ack    <= 1'b0;
      mask      <= '0;
      status    <= '0;
      irq       <= 1'b0;
    end else begin
      port_wstb <= '0;
      io_ack    <= enter_ack;
      irq       <= |(status & mask);
      status    <= (status & ~clr) | chg;
      if (writeRgDir) dir <= {inreg2, inreg1};

      case (state)
        ST_IDLE: begin
          if (io_start) begin
            op_we    <= io_we;
            op_hit   <= cur_hit;
            op_ofs   <= cur_ofs;
            op_wdata <= wdata;
            wcnt     <= '0;
            state    <= (WAIT_CYC == 0) ? ST_ACK : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (enter_ack) state <= ST_ACK;
          else           wcnt  <= wcnt + 1'b1;
        end
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      // Results land on the edge entering ACK so they are valid with io_ack.
      if (enter_ack) begin
        if (cur_we) begin
          if (cur_hit) begin
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
              if (cur_ofs == ADDR_W'(k)) begin
                port_out[k*DATA_W +: DATA_W] <= cur_wdata;
                port_wstb[k]                 <= 1'b1;
              end
            end
            if (cur_ofs == ADDR_W'(OFS_MASK(NUM_PORTS))) mask[NB-1:0] <= cur_wdata[NB-1:0];
          end
        end else begin
          rdata <= rd_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Bench for io_port_ctrl: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model of the port controller.
module tb_io_port_ctrl;

  localparam int NP = 4;
  localparam int WC = 3;
  localparam logic [15:0] BASE = 16'h0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  inreg1 = '0, inreg2 = '0;
  logic        writeRgDir = 1'b0, io_start = 1'b0, io_we = 1'b0;
  logic [7:0]  wdata = '0;
  logic [7:0]  rdata;
  logic        io_ack, io_busy, irq;
  logic [15:0] dir;
  logic [31:0] port_out;
  logic [3:0]  port_wstb;
  logic [31:0] port_in = '0;

  int checks = 0, failures = 0, acks = 0;

  io_port_ctrl #(
    .DATA_W(8), .ADDR_W(16), .NUM_PORTS(NP), .BASE_ADDR(BASE), .WAIT_CYC(WC)
  ) dut (
    .clk(clk), .reset(reset), .inreg1(inreg1), .inreg2(inreg2),
    .writeRgDir(writeRgDir), .io_start(io_start), .io_we(io_we), .wdata(wdata),
    .rdata(rdata), .io_ack(io_ack), .io_busy(io_busy), .dir(dir),
    .port_out(port_out), .port_wstb(port_wstb), .port_in(port_in), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pbyte(input logic [31:0] v, input int k);
    return v[k*8 +: 8];
  endfunction

  // Transaction-level model: an access occupies WC+1 busy cycles and takes
  // effect as it enters its last one; inputs are seen two samples late.
  bit          mv = 1'b0;
  logic [15:0] m_dir;
  logic [7:0]  m_port [NP];
  logic [3:0]  m_wstb, m_mask, m_status, m_chg, m_clr, pre_st, pre_mk;
  logic [7:0]  m_rdata;
  logic        m_ack, m_irq;
  logic [31:0] h0, h1, h2;
  int          rem;
  logic        t_we;
  int          t_ofs;
  logic [7:0]  t_wdata;

  always @(posedge clk) begin
    if (reset) begin
      mv = 1'b1;
      m_dir = '0;
      for (int k = 0; k < NP; k++) m_port[k] = '0;
      m_wstb = '0; m_mask = '0; m_status = '0; m_rdata = '0;
      m_ack = 1'b0; m_irq = 1'b0;
      h0 = '0; h1 = '0; h2 = '0;
      rem = 0;
    end else begin
      for (int k = 0; k < NP; k++) m_chg[k] = (pbyte(h1, k) != pbyte(h2, k));
      pre_st = m_status; pre_mk = m_mask;
      m_clr = '0; m_wstb = '0; m_ack = 1'b0;
      if (rem > 0) rem--;
      else if (io_start) begin
        t_we = io_we; t_ofs = int'(m_dir) - int'(BASE); t_wdata = wdata;
        rem = WC + 1;
      end
      if (rem == 1) begin
        m_ack = 1'b1;
        if (t_we) begin
          if (t_ofs >= 0 && t_ofs < NP) begin
            m_port[t_ofs] = t_wdata;
            m_wstb[t_ofs] = 1'b1;
          end else if (t_ofs == NP)     m_mask = t_wdata[3:0];
          else if (t_ofs == NP + 1)     m_clr  = t_wdata[3:0];
        end else begin
          if (t_ofs >= 0 && t_ofs < NP) m_rdata = pbyte(h1, t_ofs);
          else if (t_ofs == NP)         m_rdata = {4'b0, pre_mk};
          else if (t_ofs == NP + 1)     m_rdata = {4'b0, pre_st};
          else                          m_rdata = '0;
        end
      end
      m_irq    = |(pre_st & pre_mk);
      m_status = (pre_st & ~m_clr) | m_chg;
      if (writeRgDir) m_dir = {inreg2, inreg1};
      h2 = h1; h1 = h0; h0 = port_in;
    end
  end

  always @(negedge clk) begin
    if (mv) begin
      check("dir", dir, m_dir);
      check("port_out", port_out, {m_port[3], m_port[2], m_port[1], m_port[0]});
      check("port_wstb", port_wstb, m_wstb);
      check("rdata", rdata, m_rdata);
      check("io_ack", io_ack, m_ack);
      check("io_busy", io_busy, rem > 0);
      check("irq", irq, m_irq);
    end
  end

  always @(posedge clk) begin
    #1;
    if (io_ack === 1'b1) acks++;
  end

  task automatic set_dir(input logic [15:0] a);
    writeRgDir = 1'b1; inreg1 = a[7:0]; inreg2 = a[15:8];
    @(negedge clk);
    writeRgDir = 1'b0;
  endtask

  task automatic access(input logic we, input logic [7:0] d, output int lat, output int bsy,
                        output logic [7:0] rd, output logic [3:0] wstb, output logic [31:0] pout);
    io_start = 1'b1; io_we = we; wdata = d;
    lat = 0; bsy = 0;
    do begin
      @(negedge clk);
      io_start = 1'b0;
      lat++;
      bsy += int'(io_busy);
    end while (io_ack !== 1'b1 && lat < 20);
    check("ack_seen", io_ack, 1'b1);
    rd = rdata; wstb = port_wstb; pout = port_out;
    @(negedge clk);
    check("busy_after_ack", io_busy, 1'b0);
  endtask

  initial begin
    int lat, bsy, n, a0;
    logic [7:0]  rd;
    logic [3:0]  ws;
    logic [31:0] po;

    repeat (3) @(negedge clk);
    check("reset_dir", dir, 16'h0000);
    check("reset_port_out", port_out, 32'h0);
    check("reset_rdata", rdata, 8'h00);
    check("reset_busy_irq", {io_busy, io_ack, irq}, 3'b000);
    reset = 1'b0;

    // 1: write A5 to port 2
    set_dir(16'h0002);
    access(1'b1, 8'hA5, lat, bsy, rd, ws, po);
    check("t1_dir", dir, 16'h0002);
    check("t1_port_out", po, 32'h00A50000);
    check("t1_wstb", ws, 4'b0100);
    check("t1_wstb_clear", port_wstb, 4'b0000);

    // 2: read port 1 with 3 wait states
    port_in[15:8] = 8'h3C;
    set_dir(16'h0001);
    repeat (3) @(negedge clk);
    access(1'b0, 8'h00, lat, bsy, rd, ws, po);
    check("t2_latency", lat, 4);
    check("t2_busy_cycles", bsy, 4);
    check("t2_rdata", rd, 8'h3C);

    // 3: mask, change detect, irq, write-1-to-clear
    set_dir(16'h0004);
    access(1'b1, 8'h01, lat, bsy, rd, ws, po);
    port_in[7:0] = 8'hFF;
    n = 0;
    while (irq !== 1'b1 && n < 8) begin @(negedge clk); n++; end
    check("t3_irq_set", irq, 1'b1);
    check("t3_irq_within_4", n <= 4, 1'b1);
    port_in[31:24] = 8'h01;
    repeat (5) @(negedge clk);
    set_dir(16'h0005);
    access(1'b0, 8'h00, lat, bsy, rd, ws, po);
    check("t3_status", rd, 8'h0B);
    check("t3_irq_masked", irq, 1'b1);
    access(1'b1, 8'h01, lat, bsy, rd, ws, po);
    repeat (3) @(negedge clk);
    check("t3_irq_cleared", irq, 1'b0);
    access(1'b0, 8'h00, lat, bsy, rd, ws, po);
    check("t3_status_after_clr", rd, 8'h0A);

    // 4: unmapped address
    set_dir(16'h0100);
    access(1'b1, 8'h77, lat, bsy, rd, ws, po);
    check("t4_write_ignored", po, 32'h00A50000);
    check("t4_wstb_none", ws, 4'b0000);
    access(1'b0, 8'h00, lat, bsy, rd, ws, po);
    check("t4_read_zero", rd, 8'h00);

    // 5: dir load coincident with start; second start while busy
    set_dir(16'h0001);
    a0 = acks;
    writeRgDir = 1'b1; inreg1 = 8'h03; inreg2 = 8'h00;
    io_start = 1'b1; io_we = 1'b1; wdata = 8'h5A;
    @(negedge clk);
    writeRgDir = 1'b0; wdata = 8'hEE;
    @(negedge clk);
    io_start = 1'b0;
    repeat (8) @(negedge clk);
    check("t5_one_ack", acks - a0, 1);
    check("t5_port_out", port_out, 32'h00A55A00);
    check("t5_dir", dir, 16'h0003);

    // 6: reset during WAIT of a write
    set_dir(16'h0000);
    a0 = acks;
    io_start = 1'b1; io_we = 1'b1; wdata = 8'h11;
    @(negedge clk);
    io_start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_port_out_reset", port_out, 32'h0);
    check("t6_dir_reset", dir, 16'h0000);
    access(1'b1, 8'h22, lat, bsy, rd, ws, po);
    check("t6_latency", lat, 4);
    check("t6_port_out", po, 32'h00000022);
    repeat (2) @(negedge clk);
    check("t6_ack_count", acks - a0, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      writeRgDir = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 9))
        0:       {inreg2, inreg1} = 16'h0100;
        1:       {inreg2, inreg1} = 16'hFFFF;
        default: {inreg2, inreg1} = 16'($urandom_range(0, 7));
      endcase
      io_start = ($urandom_range(0, 3) == 0);
      io_we    = 1'($urandom);
      wdata    = 8'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        n = $urandom_range(0, NP - 1);
        port_in[n*8 +: 8] = 8'($urandom);
      end
      reset = ($urandom_range(0, 399) == 0);
      @(negedge clk);
    end
    writeRgDir = 1'b0; io_start = 1'b0; reset = 1'b0;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_port_ctrl.md
Name: io_port_ctrl

Overview:
Parametrised memory-mapped I/O controller that generalises the single-channel direction/address block to NUM_PORTS input and output channels. A 16-bit device address is latched from two register-file bytes. Accesses are decoded to per-port registered outputs or synchronised inputs, using a start/ack handshake with programmable wait states. Adds input change detection with a maskable interrupt. Sits between the CPU datapath (register file, control unit) and the board-level devices.

Parameters:
DATA_W, 8, width of data bus and of every port
ADDR_W, 16, device address width (lo/hi halves of DATA_W each; ADDR_W = 2*DATA_W)
NUM_PORTS, 4, number of input ports and output ports (1..32)
BASE_ADDR, 16'h0000, address of port 0
WAIT_CYC, 0, extra wait states per access (0..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
inreg1  in  DATA_W  address low byte from register file
inreg2  in  DATA_W  address high byte from register file
writeRgDir  in  1  latch {inreg2,inreg1} into address register
io_start  in  1  one-cycle access request
io_we  in  1  1 = write, 0 = read; sampled with io_start
wdata  in  DATA_W  write data
rdata  out  DATA_W  read data, valid when io_ack=1 on a read
io_ack  out  1  one-cycle access completion pulse
io_busy  out  1  access in progress
dir  out  ADDR_W  current address register
port_out  out  NUM_PORTS*DATA_W  registered output ports, port k at [k*DATA_W +: DATA_W]
port_wstb  out  NUM_PORTS  one-cycle strobe on the port just written
port_in  in  NUM_PORTS*DATA_W  asynchronous device inputs
irq  out  1  level interrupt: |(status & mask)

Behaviour:
- Reset values: dir=0, port_out=0, port_wstb=0, rdata=0, io_ack=0, io_busy=0, mask=0, status=0, irq=0, synchronisers=0, FSM=IDLE.
- Address map, offset = dir - BASE_ADDR:
  - 0..NUM_PORTS-1: data ports.
  - NUM_PORTS: MASK register (R/W, bit k enables port k).
  - NUM_PORTS+1: STATUS register (read; write-1-to-clear).
  - Any other offset, including dir < BASE_ADDR: unmapped. Writes are ignored, reads return 0, and io_ack is still given.
  - MASK/STATUS use the low NUM_PORTS bits; unused bits read 0.
- Address register: loads on writeRgDir at the rising edge. If writeRgDir and io_start occur in the same cycle, the access uses the previous dir.
- Input path: 2-flop synchroniser per port; the read value comes from the second stage. Change detect: status[k] sets when stage2 != stage3 (previous sample).
- FSM:
  - IDLE: io_start latches the operation, offset and wdata, and goes to WAIT if WAIT_CYC>0, else to ACK. io_start outside IDLE is ignored; no queueing.
  - WAIT: a 4-bit counter counts WAIT_CYC cycles, then goes to ACK.
  - ACK: performs the write or captures rdata, pulses io_ack for 1 cycle, then returns to IDLE.
- Latency: io_ack fires exactly 1+WAIT_CYC cycles after the io_start cycle. io_busy=1 from the cycle after io_start until the ack cycle inclusive.
- Writes: port_out[k] updates at the ACK edge, and port_wstb[k] pulses in the same cycle the new value appears.
- rdata holds its value until the next read ack.
- STATUS clear vs. set in the same cycle: set wins.
- irq is registered, so it lags status by 1 cycle.
- Reset asserted mid-access: returns to IDLE with no ack, the write is not performed, and all state takes its reset values.

Decomposition:
- Shared package io_pkg: FSM state encoding (IDLE, WAIT, ACK), offset constants OFS_MASK(NUM_PORTS) and OFS_STATUS(NUM_PORTS), WAIT counter width.
- One sub-module io_sync_edge (DATA_W-wide 2-flop synchroniser plus change flag), instantiated NUM_PORTS times with a generate loop.

Test Plan:
1. Reset, then writeRgDir with inreg1=8'h02, inreg2=8'h00; write 8'hA5 -> dir=16'h0002; port_out[2]=8'hA5 with port_wstb=4'b0100 for exactly 1 cycle at the ack; other ports stay 0.
2. WAIT_CYC=3, port_in[1]=8'h3C held for 3 cycles, read at dir=1 -> io_ack 4 cycles after io_start, rdata=8'h3C, io_busy high 4 cycles.
3. mask=4'b0001 written at dir=4; port_in[0] changes 00->FF -> status bit0=1 and irq=1 within 4 cycles. A change on port_in[3] sets status bit3 but leaves irq unaffected. Writing 4'b0001 to dir=5 clears bit0 and drops irq.
4. dir=16'h0100 (unmapped): write 8'h77 then read -> both acked, all port_out unchanged, rdata=0.
5. writeRgDir (new dir=3) in the same cycle as a write-start while dir=1 -> port_out[1] written, port_out[3] untouched. A second io_start while busy is ignored (only one ack).
6. reset pulsed during WAIT of a write -> no io_ack, port_out remains 0, FSM accepts a new io_start the cycle after reset deasserts.
